// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue side of the adiabatic ALU frame protocol (FIFO, decode, frame hold, result capture).
// Optional phase-consistency monitor is compiled in when ALU_SEQ_PHASE_CHECK_EN is defined.
module alu_op_sequencer #(
    parameter int CLK_WIDTH  = 13,
    parameter int DATA_WIDTH = 16,
    parameter int OP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instFlag,
    input  logic [CLK_WIDTH-1:0]  clkpos,
    input  logic [CLK_WIDTH-1:0]  clkneg,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [15:0]           op_instr,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [9:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic [15:0]           instr_in,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  out_Zero_Detect,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_zero,
    output logic                  err_illegal,
    output logic                  err_timeout,
    output logic                  phase_err
);

    localparam int PTR_W = $clog2(OP_DEPTH);
    localparam int CNT_W = $clog2(OP_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    function automatic logic [9:0] decode_ctrl(input logic [3:0] opc);
        logic [9:0] ctrl;
        case (opc)
            4'h0:    ctrl = 10'h00E;
            4'h1:    ctrl = 10'h03E;
            4'h2:    ctrl = 10'h07E;
            4'h3:    ctrl = 10'h00C;
            4'h4:    ctrl = 10'h00D;
            4'h5:    ctrl = 10'h00F;
            4'h6:    ctrl = 10'h00A;
            4'h7:    ctrl = 10'h00E;
            default: ctrl = 10'h000;
        endcase
        return ctrl;
    endfunction

    state_t                state_r, state_nxt_s;
    logic [15:0]           fifo_instr_r [OP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_a_r     [OP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b_r     [OP_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, sel_ptr_s;
    logic [CNT_W-1:0]      count_r, count_nxt_s;
    logic                  instflag_q_r, fe_s, plateau_s, push_s;
    logic                  try_issue_s, issue_s, nop_s, illegal_s, timeout_s, capture_s;
    logic [1:0]            pop_cnt_s;
    logic                  head_illegal_s, second_illegal_s;
    logic [15:0]           sel_instr_s;
    logic [DATA_WIDTH-1:0] sel_a_s, sel_b_s;
    logic                  op_ready_r, res_valid_r, res_zero_r, err_illegal_r, err_timeout_r;
    logic [9:0]            alu_ctrl_r;
    logic [DATA_WIDTH-1:0] a_r, b_r, res_data_r;
    logic [15:0]           instr_in_r;

    assign fe_s             = instFlag & ~instflag_q_r;
    assign plateau_s        = (clkpos == {CLK_WIDTH{1'b1}}) && (clkneg == {CLK_WIDTH{1'b0}});
    assign push_s           = op_valid & op_ready_r;
    assign rd_ptr_nxt_s     = rd_ptr_r + PTR_W'(1);
    assign head_illegal_s   = fifo_instr_r[rd_ptr_r][15];
    assign second_illegal_s = fifo_instr_r[rd_ptr_nxt_s][15];
    assign sel_instr_s      = fifo_instr_r[sel_ptr_s];
    assign sel_a_s          = fifo_a_r[sel_ptr_s];
    assign sel_b_s          = fifo_b_r[sel_ptr_s];
    assign count_nxt_s      = count_r + CNT_W'(push_s) - CNT_W'(pop_cnt_s);

    // Frame FSM next state and per-cycle issue/capture decisions
    always_comb begin
        state_nxt_s = state_r;
        try_issue_s = 1'b0;
        issue_s     = 1'b0;
        nop_s       = 1'b0;
        illegal_s   = 1'b0;
        timeout_s   = 1'b0;
        capture_s   = 1'b0;
        pop_cnt_s   = 2'd0;
        sel_ptr_s   = rd_ptr_r;
        case (state_r)
            S_IDLE: begin
                try_issue_s = fe_s & ~res_valid_r;
            end
            S_EVAL: begin
                if (plateau_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = S_RESULT;
                end else if (fe_s) begin
                    timeout_s   = 1'b1;
                    try_issue_s = 1'b1;
                end else begin
                    state_nxt_s = S_EVAL;
                end
            end
            S_RESULT: begin
                try_issue_s = fe_s & ~res_valid_r;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        // An illegal head is dropped and only the single entry behind it gets a chance this frame
        if (try_issue_s) begin
            if (count_r == {CNT_W{1'b0}}) begin
                nop_s       = 1'b1;
                state_nxt_s = S_IDLE;
            end else if (!head_illegal_s) begin
                pop_cnt_s   = 2'd1;
                issue_s     = 1'b1;
                state_nxt_s = S_EVAL;
            end else begin
                illegal_s = 1'b1;
                if ((count_r >= CNT_W'(2)) && !second_illegal_s) begin
                    pop_cnt_s   = 2'd2;
                    issue_s     = 1'b1;
                    sel_ptr_s   = rd_ptr_nxt_s;
                    state_nxt_s = S_EVAL;
                end else begin
                    pop_cnt_s   = 2'd1;
                    nop_s       = 1'b1;
                    state_nxt_s = S_IDLE;
                end
            end
        end else begin
            pop_cnt_s = pop_cnt_s;
        end
    end

    // State register and frame-edge history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            instflag_q_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            instflag_q_r <= instFlag;
        end
    end

    // Operation FIFO storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OP_DEPTH; i++) begin
                fifo_instr_r[i] <= 16'h0000;
                fifo_a_r[i]     <= {DATA_WIDTH{1'b0}};
                fifo_b_r[i]     <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= op_instr;
            fifo_a_r[wr_ptr_r]     <= op_a;
            fifo_b_r[wr_ptr_r]     <= op_b;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            op_ready_r <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_r + PTR_W'(pop_cnt_s);
            wr_ptr_r   <= wr_ptr_r + PTR_W'(push_s);
            count_r    <= count_nxt_s;
            op_ready_r <= (count_nxt_s != CNT_W'(OP_DEPTH));
        end
    end

    // ALU pins: loaded only on a frame edge, otherwise held for the whole frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_ctrl_r <= 10'h000;
            a_r        <= {DATA_WIDTH{1'b0}};
            b_r        <= {DATA_WIDTH{1'b0}};
            instr_in_r <= 16'h0000;
        end else if (issue_s) begin
            alu_ctrl_r <= decode_ctrl(sel_instr_s[15:12]);
            a_r        <= (sel_instr_s[15:12] == 4'h7) ? {DATA_WIDTH{1'b0}} : sel_a_s;
            b_r        <= sel_b_s;
            instr_in_r <= {4'h0, sel_instr_s[11:0]};
        end else if (nop_s) begin
            alu_ctrl_r <= 10'h000;
            a_r        <= {DATA_WIDTH{1'b0}};
            b_r        <= {DATA_WIDTH{1'b0}};
            instr_in_r <= 16'h0000;
        end
    end

    // Result capture on the plateau and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_r   <= 1'b0;
            res_data_r    <= {DATA_WIDTH{1'b0}};
            res_zero_r    <= 1'b0;
            err_illegal_r <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            if (capture_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= alu_out;
                res_zero_r  <= out_Zero_Detect;
            end else if (res_valid_r && res_ready) begin
                res_valid_r <= 1'b0;
            end
            err_illegal_r <= err_illegal_r | illegal_s;
            err_timeout_r <= err_timeout_r | timeout_s;
        end
    end

`ifdef ALU_SEQ_PHASE_CHECK_EN
    logic phase_err_r;

    // Sticky flag for complementary-phase violations while an op is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_err_r <= 1'b0;
        end else if ((state_r == S_EVAL) && (clkpos != ~clkneg)) begin
            phase_err_r <= 1'b1;
        end
    end

    assign phase_err = phase_err_r;
`else
    assign phase_err = 1'b0;
`endif

    assign op_ready    = op_ready_r;
    assign alu_ctrl    = alu_ctrl_r;
    assign a           = a_r;
    assign b           = b_r;
    assign instr_in    = instr_in_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_zero    = res_zero_r;
    assign err_illegal = err_illegal_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized frames against a queue-based reference model, with a
// behavioural ALU stub driven from the DUT pins.
module tb_alu_op_sequencer;

    localparam int CW    = 13;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    localparam logic [9:0] CTRL_TBL [8] = '{10'h00E, 10'h03E, 10'h07E, 10'h00C,
                                             10'h00D, 10'h00F, 10'h00A, 10'h00E};

    logic          clk, reset, instFlag;
    logic [CW-1:0] clkpos, clkneg;
    logic          op_valid, op_ready;
    logic [15:0]   op_instr;
    logic [DW-1:0] op_a, op_b;
    logic [9:0]    alu_ctrl;
    logic [DW-1:0] a, b;
    logic [15:0]   instr_in;
    logic [DW-1:0] alu_out;
    logic          out_Zero_Detect;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic          res_zero, err_illegal, err_timeout, phase_err;

    int checks = 0;
    int errors = 0;
    int rr_mode;
    bit offer_all;
    op_t stim_q[$];

    // reference model state
    op_t         m_q[$];
    op_t         m_cur;
    bit          m_inflight, m_res_valid, m_res_zero, m_err_ill, m_err_to, m_ready, m_prev_if;
    logic [15:0] m_res_data;
    logic [9:0]  e_ctrl;
    logic [15:0] e_a, e_b, e_instr;

    alu_op_sequencer #(.CLK_WIDTH(CW), .DATA_WIDTH(DW), .OP_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .instFlag(instFlag), .clkpos(clkpos), .clkneg(clkneg),
        .op_valid(op_valid), .op_ready(op_ready), .op_instr(op_instr), .op_a(op_a), .op_b(op_b),
        .alu_ctrl(alu_ctrl), .a(a), .b(b), .instr_in(instr_in), .alu_out(alu_out),
        .out_Zero_Detect(out_Zero_Detect), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .err_illegal(err_illegal),
        .err_timeout(err_timeout), .phase_err(phase_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU stand-in: reacts to the control word on the pins
    always_comb begin
        case (alu_ctrl)
            10'h00E: alu_out = a + b;
            10'h03E: alu_out = a - b;
            10'h07E: alu_out = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            10'h00C: alu_out = a & b;
            10'h00D: alu_out = a | b;
            10'h00F: alu_out = a ^ b;
            10'h00A: alu_out = a + instr_in;
            default: alu_out = 16'h0000;
        endcase
        out_Zero_Detect = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input op_t op);
        logic [15:0] imm;
        imm = {4'h0, op.instr[11:0]};
        case (op.instr[15:12])
            4'h0:    return op.a + op.b;
            4'h1:    return op.a - op.b;
            4'h2:    return ($signed(op.a) < $signed(op.b)) ? 16'd1 : 16'd0;
            4'h3:    return op.a & op.b;
            4'h4:    return op.a | op.b;
            4'h5:    return op.a ^ op.b;
            4'h6:    return op.a + imm;
            default: return op.b;
        endcase
    endfunction

    function automatic op_t mk(input logic [3:0] opc, input logic [11:0] imm,
                               input logic [15:0] av, input logic [15:0] bv);
        op_t op;
        op.instr = {opc, imm};
        op.a     = av;
        op.b     = bv;
        return op;
    endfunction

    function automatic op_t rnd_op(input bit allow_illegal);
        logic [3:0]  opc;
        logic [15:0] av, bv;
        if (allow_illegal && $urandom_range(0, 7) == 0) opc = 4'($urandom_range(8, 15));
        else opc = 4'($urandom_range(0, 7));
        av = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        bv = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        return mk(opc, 12'($urandom), av, bv);
    endfunction

    task automatic model_issue();
        op_t h;
        bit  go;
        go = 1'b0;
        if (m_q.size() > 0) begin
            h = m_q.pop_front();
            if (!h.instr[15]) begin
                go = 1'b1;
            end else begin
                m_err_ill = 1'b1;
                if (m_q.size() > 0 && !m_q[0].instr[15]) begin
                    h  = m_q.pop_front();
                    go = 1'b1;
                end
            end
        end
        if (go) begin
            e_ctrl     = CTRL_TBL[h.instr[14:12]];
            e_a        = (h.instr[15:12] == 4'h7) ? 16'h0000 : h.a;
            e_b        = h.b;
            e_instr    = {4'h0, h.instr[11:0]};
            m_cur      = h;
            m_inflight = 1'b1;
        end else begin
            e_ctrl = 10'h000; e_a = 16'h0; e_b = 16'h0; e_instr = 16'h0;
        end
    endtask

    // what the upcoming rising edge does, given the inputs now applied
    task automatic model_edge();
        bit fe, plat, rv_old, rdy_old;
        fe      = instFlag && !m_prev_if;
        plat    = (clkpos == {CW{1'b1}}) && (clkneg == {CW{1'b0}});
        rv_old  = m_res_valid;
        rdy_old = m_ready;
        if (m_res_valid && res_ready) m_res_valid = 1'b0;
        if (m_inflight && plat) begin
            m_res_valid = 1'b1;
            m_res_data  = ref_result(m_cur);
            m_res_zero  = (m_res_data == 16'h0000);
            m_inflight  = 1'b0;
        end else if (fe && !rv_old) begin
            if (m_inflight) begin
                m_err_to   = 1'b1;
                m_inflight = 1'b0;
            end
            model_issue();
        end
        if (op_valid && rdy_old) begin
            m_q.push_back(stim_q.pop_front());
        end
        m_ready   = (m_q.size() < DEPTH);
        m_prev_if = instFlag;
    endtask

    task automatic check_all();
        check("op_ready", op_ready, m_ready);
        check("alu_ctrl", alu_ctrl, e_ctrl);
        check("a", a, e_a);
        check("b", b, e_b);
        check("instr_in", instr_in, e_instr);
        check("res_valid", res_valid, m_res_valid);
        check("res_data", res_data, m_res_data);
        check("res_zero", res_zero, m_res_zero);
        check("err_illegal", err_illegal, m_err_ill);
        check("err_timeout", err_timeout, m_err_to);
        check("phase_err", phase_err, 1'b0);
    endtask

    task automatic drive_side();
        if (stim_q.size() > 0 && (offer_all || op_valid || $urandom_range(0, 1) == 1)) begin
            op_valid = 1'b1;
            op_instr = stim_q[0].instr;
            op_a     = stim_q[0].a;
            op_b     = stim_q[0].b;
        end else begin
            op_valid = 1'b0;
            op_instr = 16'($urandom);
            op_a     = 16'($urandom);
            op_b     = 16'($urandom);
        end
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_op_ready", op_ready, 1'b0);
        check("rst_alu_ctrl", alu_ctrl, 10'h000);
        check("rst_a", a, 16'h0);
        check("rst_b", b, 16'h0);
        check("rst_instr_in", instr_in, 16'h0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 16'h0);
        check("rst_res_zero", res_zero, 1'b0);
        check("rst_err_illegal", err_illegal, 1'b0);
        check("rst_err_timeout", err_timeout, 1'b0);
        check("rst_phase_err", phase_err, 1'b0);
        op_valid = 1'b0; instFlag = 1'b0; clkpos = '0; clkneg = '1;
        stim_q.delete();
        m_q.delete();
        m_inflight = 1'b0; m_res_valid = 1'b0; m_res_zero = 1'b0; m_res_data = 16'h0;
        m_err_ill = 1'b0; m_err_to = 1'b0; m_ready = 1'b0; m_prev_if = 1'b0;
        e_ctrl = 10'h000; e_a = 16'h0; e_b = 16'h0; e_instr = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            instFlag = 1'b0; clkpos = '0; clkneg = '1;
            drive_side();
            cycle();
        end
    endtask

    task automatic frame(input int len, input int plat, input int rst_at);
        for (int c = 0; c < len; c++) begin
            if (c == rst_at) begin
                do_reset();
                return;
            end
            instFlag = (c == 0);
            clkpos   = (c == plat) ? {CW{1'b1}} : {CW{1'b0}};
            clkneg   = (c == plat) ? {CW{1'b0}} : {CW{1'b1}};
            drive_side();
            cycle();
        end
    endtask

    initial begin
        reset = 1'b0; instFlag = 1'b0; clkpos = '0; clkneg = '1;
        op_valid = 1'b0; op_instr = 16'h0; op_a = 16'h0; op_b = 16'h0; res_ready = 1'b0;
        offer_all = 1'b1; rr_mode = 1;
        @(negedge clk);
        do_reset();
        idle(2);

        // ADD 1+2
        rr_mode = 0;
        stim_q.push_back(mk(4'h0, 12'h000, 16'd1, 16'd2));
        idle(3);
        frame(10, 5, -1);
        check("t1_ctrl", alu_ctrl, 10'h00E);
        check("t1_res_valid", res_valid, 1'b1);
        check("t1_res_data", res_data, 16'd3);
        check("t1_res_zero", res_zero, 1'b0);
        rr_mode = 1;
        idle(2);

        // SUB 5-5
        rr_mode = 0;
        stim_q.push_back(mk(4'h1, 12'h000, 16'd5, 16'd5));
        idle(3);
        frame(10, 5, -1);
        check("t2_ctrl", alu_ctrl, 10'h03E);
        check("t2_res_data", res_data, 16'd0);
        check("t2_res_zero", res_zero, 1'b1);
        rr_mode = 1;
        idle(2);

        // five back-to-back pushes into a four-deep FIFO
        for (int i = 0; i < 5; i++) stim_q.push_back(rnd_op(1'b0));
        idle(6);
        check("t3_full", op_ready, 1'b0);
        repeat (6) frame(10, 5, -1);

        // consumer stalls for two frames
        rr_mode = 0;
        stim_q.push_back(rnd_op(1'b0));
        stim_q.push_back(rnd_op(1'b0));
        idle(3);
        repeat (3) frame(10, 5, -1);
        rr_mode = 1;
        repeat (3) frame(10, 5, -1);

        // illegal opcode followed by ADD in the same frame
        stim_q.push_back(mk(4'hC, 12'h000, 16'd3, 16'd4));
        stim_q.push_back(mk(4'h0, 12'h000, 16'd7, 16'd9));
        idle(3);
        frame(10, 5, -1);
        check("t5_err_illegal", err_illegal, 1'b1);
        check("t5_ctrl", alu_ctrl, 10'h00E);
        check("t5_res_data", res_data, 16'd16);

        // frame with no plateau
        stim_q.push_back(mk(4'h5, 12'h000, 16'h00F0, 16'h0FF0));
        idle(3);
        frame(10, -1, -1);
        frame(10, 5, -1);
        check("to_err_timeout", err_timeout, 1'b1);

        // randomized traffic
        offer_all = 1'b0;
        rr_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int len, plat;
            if ($urandom_range(0, 9) < 6) stim_q.push_back(rnd_op(1'b1));
            if ($urandom_range(0, 9) < 2) stim_q.push_back(rnd_op(1'b1));
            len  = $urandom_range(8, 14);
            plat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(2, len - 2);
            frame(len, plat, -1);
        end
        rr_mode = 1;
        offer_all = 1'b1;
        repeat (6) frame(10, 5, -1);

        // reset while an op is in flight
        stim_q.push_back(mk(4'h0, 12'h000, 16'd10, 16'd20));
        idle(3);
        frame(10, 5, 3);
        idle(2);
        check("t6_op_ready", op_ready, 1'b1);
        check("t6_res_valid", res_valid, 1'b0);
        check("t6_ctrl", alu_ctrl, 10'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
